sram_stream_reader: RTL and testbench

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

---
 rtl/sram_stream_reader.sv | 148 ++++++++++++++
 tb/tb_sram_stream_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_reader.sv
// Avalon-MM read master that streams word_count words from base_addr into a credit-limited output FIFO.
// Optional feature: define SRAM_STREAM_ABORT_EN to add the abort input.
module sram_stream_reader #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
`ifdef SRAM_STREAM_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] av_address,
  output logic [BE_WIDTH-1:0]   av_byteenable,
  output logic                  av_read,
  input  logic                  av_waitrequest,
  input  logic [DATA_WIDTH-1:0] av_readdata,
  input  logic                  av_readdataready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] L_DEPTH = (CW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_done;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_fifo_cnt;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic          w_credit;
  logic          w_accept;
  logic          w_last;
  logic          w_push;
  logic          w_pop;
  logic          w_abort;
  logic [CW:0]   w_inflight;

  // Words in the FIFO plus reads still in flight can never exceed the FIFO size,
  // so every returned word is guaranteed a slot.
  assign w_inflight = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
  assign w_credit   = w_inflight < L_DEPTH;

  assign av_read  = (r_state == ISSUE) && (r_remaining != '0) && w_credit;
  assign w_accept = av_read && !av_waitrequest;
  assign w_last   = w_accept && (r_remaining == ADDR_WIDTH'(1));
  assign w_push   = av_readdataready && (r_outstanding != '0);
  assign w_pop    = dout_valid && dout_ready;

`ifdef SRAM_STREAM_ABORT_EN
  assign w_abort = abort && (r_state == ISSUE);
`else
  assign w_abort = 1'b0;
`endif

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign av_address    = r_addr;
  assign av_byteenable = '1;
  assign dout          = r_mem[r_rd_ptr];
  assign dout_valid    = (r_fifo_cnt != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - ADDR_WIDTH'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              r_addr      <= base_addr;
              r_remaining <= word_count;
              r_state     <= ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (w_last || w_abort) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_outstanding == '0) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_mem         <= '{default: '0};
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
      if (w_push) begin
        r_mem[r_wr_ptr] <= av_readdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized bench for sram_stream_reader: an in-order SRAM slave plus a word-stream model
// that predicts addresses, data order, credit limits and done behaviour.
module tb_sram_stream_reader;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          busy;
  logic          done;
  logic [AW-1:0] av_address;
  logic [DW/8-1:0] av_byteenable;
  logic          av_read;
  logic          av_waitrequest;
  logic [DW-1:0] av_readdata;
  logic          av_readdataready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
`ifdef SRAM_STREAM_ABORT_EN
  logic          abort;
`endif

  sram_stream_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .word_count       (word_count),
`ifdef SRAM_STREAM_ABORT_EN
    .abort            (abort),
`endif
    .busy             (busy),
    .done             (done),
    .av_address       (av_address),
    .av_byteenable    (av_byteenable),
    .av_read          (av_read),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdataready (av_readdataready),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int wait_pct  = 0;
  int ready_pct = 100;
  int lat       = 1;

  logic [AW-1:0] job_base  = '0;
  logic [AW-1:0] job_count = '0;
  int acc_n    = 0;
  int pop_n    = 0;
  int n_done   = 0;
  int inflight = 0;
  int first_acc_cyc   = -1;
  int first_valid_cyc = -1;
  bit aborting   = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_busy  = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] acc_log[$];
  logic [DW-1:0] pop_log[$];
  int            pend_due[$];
  logic [DW-1:0] pend_data[$];

  // Memory contents seen by the slave: a fixed function of the word address.
  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hC35A ^ {12'h000, a[19:16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: new inputs 1 time unit after the rising edge; the slave returns data lat cycles after acceptance.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    av_waitrequest   = ($urandom_range(99) < wait_pct);
    dout_ready       = ($urandom_range(99) < ready_pct);
    av_readdata      = DW'($urandom);
    av_readdataready = 1'b0;
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      av_readdataready = 1'b1;
      av_readdata      = pend_data[0];
      pend_due.delete(0);
      pend_data.delete(0);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      inflight   = 0;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      chk("byteenable", av_byteenable, 64'h3);
      if (prev_stall && !aborting) begin
        chk("hold_read", av_read, 1);
        chk("hold_addr", av_address, prev_addr);
      end
      if (av_read) begin
        ea = AW'(job_base + acc_n);
        chk("read_while_busy", busy, 1);
        chk("read_credit", inflight < FD, 1);
        chk("read_left", acc_n < job_count, 1);
        chk("read_addr", av_address, ea);
        if (!av_waitrequest) begin
          acc_log.push_back(av_address);
          exp_q.push_back(data_of(ea));
          pend_due.push_back(cyc + lat);
          pend_data.push_back(data_of(av_address));
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
          acc_n++;
          inflight++;
        end
      end
      if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pop", 1, 0);
        end else begin
          ed = exp_q.pop_front();
          chk("dout", dout, ed);
        end
        pop_log.push_back(dout);
        pop_n++;
        inflight--;
      end
      if (done) begin
        n_done++;
        chk("done_busy_low", busy, 0);
        chk("done_prev_busy", prev_busy, job_count != 0);
        if (!aborting) chk("done_all_issued", acc_n, job_count);
        chk("done_after_returns", pend_due.size(), 0);
      end
      prev_stall = av_read && av_waitrequest;
      prev_addr  = av_address;
      prev_busy  = busy;
    end
  end

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] c);
    tick();
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    job_base   = b;
    job_count  = c;
    acc_n      = 0;
    pop_n      = 0;
    n_done     = 0;
    aborting   = 1'b0;
    first_acc_cyc   = -1;
    first_valid_cyc = -1;
    acc_log.delete();
    pop_log.delete();
    tick();
    start      = 1'b0;
    base_addr  = AW'($urandom);
    word_count = AW'($urandom);
    chk("busy_after_start", busy, c != 0);
  endtask

  task automatic finish_job(input int bound, input int exp_words);
    int t;
    t = 0;
    while (n_done == 0 && t < bound) begin
      tick();
      t++;
    end
    chk("done_seen", n_done, 1);
    ready_pct = 100;
    t = 0;
    while ((exp_q.size() != 0 || pend_due.size() != 0) && t < bound) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk("single_done", n_done, 1);
    chk("words_delivered", pop_n, exp_words);
    chk("fifo_empty_after", dout_valid, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int t;
    logic [AW-1:0] exp_wrap [4];
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    av_waitrequest = 1'b0;
    av_readdata = '0;
    av_readdataready = 1'b0;
    dout_ready = 1'b0;
`ifdef SRAM_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_av_read", av_read, 0);
    chk("rst_av_address", av_address, 0);
    chk("rst_byteenable", av_byteenable, 64'h3);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b0;
    tick();

    // Basic streaming with latency 1 and no stalls.
    lat = 1; wait_pct = 0; ready_pct = 100;
    start_job(20'h00100, 20'd8);
    finish_job(200, 8);
    chk("basic_count", acc_log.size(), 8);
    if (acc_log.size() == 8) begin
      chk("basic_addr0", acc_log[0], 20'h00100);
      chk("basic_addr7", acc_log[7], 20'h00107);
    end
    if (pop_log.size() == 8) begin
      chk("basic_data0", pop_log[0], 16'hC25A);
      chk("basic_data7", pop_log[7], 16'hC25D);
    end
    chk("first_word_latency", first_valid_cyc - first_acc_cyc, lat + 1);

    // Consumer stalled: credit limits the job to FD reads until words are popped.
    lat = 2; wait_pct = 0; ready_pct = 0;
    start_job(20'h02000, 20'd10);
    repeat (30) tick();
    chk("credit_accepted", acc_n, 4);
    chk("credit_read_low", av_read, 0);
    chk("credit_valid", dout_valid, 1);
    ready_pct = 100;
    finish_job(300, 10);

    // Address wrap at the top of the address space with random stalls.
    lat = 2; wait_pct = 50; ready_pct = 70;
    start_job(20'hFFFFE, 20'd4);
    finish_job(400, 4);
    exp_wrap[0] = 20'hFFFFE; exp_wrap[1] = 20'hFFFFF; exp_wrap[2] = 20'h00000; exp_wrap[3] = 20'h00001;
    chk("wrap_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("wrap_addr", acc_log[i], exp_wrap[i]);
    if (pop_log.size() == 4) begin
      chk("wrap_data0", pop_log[0], 16'h3CAB);
      chk("wrap_data2", pop_log[2], 16'hC35A);
    end

    // Zero-length job, then a start while busy that must be ignored.
    lat = 1; wait_pct = 0; ready_pct = 100;
    start_job(20'h00300, 20'd0);
    chk("zero_done", done, 1);
    chk("zero_read", av_read, 0);
    tick();
    chk("zero_done_once", done, 0);
    chk("zero_busy", busy, 0);
    chk("zero_done_count", n_done, 1);
    start_job(20'h00400, 20'd6);
    tick();
    start = 1'b1; base_addr = 20'h55555; word_count = 20'd3;
    tick();
    start = 1'b0;
    finish_job(200, 6);

    // Reset in the middle of a job: no done, late returns ignored, next job clean.
    lat = 3; wait_pct = 30; ready_pct = 0;
    start_job(20'h00700, 20'd8);
    t = 0;
    while (acc_n < 3 && t < 200) begin
      tick();
      t++;
    end
    chk("pre_reset_accepted", acc_n, 3);
    av_waitrequest = 1'b1;
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_av_read", av_read, 0);
    chk("mid_rst_av_address", av_address, 0);
    chk("mid_rst_byteenable", av_byteenable, 64'h3);
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    reset = 1'b0;
    ready_pct = 100;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("late_return_ignored", dout_valid, 0);
      chk("no_done_after_reset", done, 0);
    end
    chk("reset_done_count", n_done, 0);
    t = 0;
    while (pend_due.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    lat = 2; wait_pct = 20;
    start_job(20'h00900, 20'd2);
    finish_job(200, 2);
    if (pop_log.size() == 2) chk("post_reset_data1", pop_log[1], 16'hCA5B);

`ifdef SRAM_STREAM_ABORT_EN
    // Abort after five accepted reads.
    lat = 2; wait_pct = 20; ready_pct = 100;
    start_job(20'h01230, 20'd16);
    t = 0;
    while (acc_n < 5 && t < 200) begin
      tick();
      t++;
    end
    av_waitrequest = 1'b1;
    abort = 1'b1;
    aborting = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_read_low", av_read, 0);
    finish_job(300, 5);
    chk("abort_accepted", acc_n, 5);
`endif

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      logic [AW-1:0] b;
      logic [AW-1:0] c;
      lat       = int'($urandom_range(4, 1));
      wait_pct  = int'($urandom_range(60));
      ready_pct = int'($urandom_range(100, 30));
      b = ($urandom_range(3) == 0) ? AW'(32'hFFFF0 + $urandom_range(15)) : AW'($urandom);
      c = AW'($urandom_range(20, 1));
      start_job(b, c);
      finish_job(3000, int'(c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
